// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver/transmitter types and baud timing helpers
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    function automatic int baud_ticks(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int half_ticks(input int clk_freq, input int baud_rate);
        return baud_ticks(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous input, resets to 1
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output; UART_RX_PARITY_EN adds a parity bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam logic [15:0] BAUD_LAST = 16'(baud_ticks(CLK_FREQ, BAUD_RATE) - 1);
    localparam logic [15:0] HALF_LAST = 16'(half_ticks(CLK_FREQ, BAUD_RATE) - 1);

`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
    localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

    uart_rx_state_t state, state_next;
    logic                 rx_s;
    logic [15:0]          count;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 half_hit, baud_hit, sample, par_bad;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign half_hit = (count == HALF_LAST);
    assign baud_hit = (count == BAUD_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        case (state)
            IDLE:   if (!rx_s) state_next = START;
            START:  if (half_hit) begin
                        sample     = 1'b1;
                        state_next = rx_s ? IDLE : DATA;
                    end
            DATA:   if (baud_hit) begin
                        sample = 1'b1;
                        if (bit_idx == 3'(DATA_BITS - 1)) state_next = AFTER_DATA;
                    end
`ifdef UART_RX_PARITY_EN
            PARITY: if (baud_hit) begin
                        sample     = 1'b1;
                        state_next = STOP;
                    end
`endif
            STOP:   if (baud_hit) begin
                        sample     = 1'b1;
                        state_next = rx_s ? IDLE : BREAK;
                    end
            BREAK:  if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            // Counter only runs while timing a bit; it restarts at every entry and sample point
            if (sample || state_next != state || state == IDLE || state == BREAK)
                count <= '0;
            else
                count <= count + 16'd1;
            if (data_valid && data_ready) data_valid <= 1'b0;
            if (state == START && state_next == DATA) bit_idx <= '0;
            if (state == DATA && sample) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
            // A byte accepted on the completion cycle frees the slot, so it is not an overrun
            if (state == STOP && sample) begin
                if (!rx_s) begin
                    frame_err <= 1'b1;
                end else if (!par_bad) begin
                    if (data_valid && !data_ready) begin
                        overrun_err <= 1'b1;
                    end else begin
                        data_out   <= shift_reg;
                        data_valid <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= (state == STOP) && sample && rx_s && par_bad;
            if (state == START)
                par_bad <= 1'b0;
            else if (state == PARITY && sample)
                par_bad <= (rx_s != ((^shift_reg) ^ (PARITY_ODD != 0)));
        end
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign par_bad           = 1'b0;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. Recovers 8N1 frames (start bit, 8 data bits LSB first, stop bit) from the asynchronous serial line and presents each byte on a valid/ready output. It is the receive-side companion of the team's UART transmitter and uses the same CLK_FREQ/BAUD_RATE timing. Sits between the board RX pin and the byte consumer (FIFO or command parser).

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; BAUD_TICKS = CLK_FREQ/BAUD_RATE (5208 at defaults), HALF_TICKS = BAUD_TICKS/2
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
data_out  output  8  received byte, valid while data_valid=1
data_valid  output  1  byte available; held until accepted
data_ready  input  1  consumer accepts byte when data_valid & data_ready
busy  output  1  frame reception in progress (state != IDLE)
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun_err  output  1  one-cycle pulse: frame completed while data_valid still high
parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without UART_RX_PARITY_EN)

Behaviour:
- rx passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized signal rx_s. Input-to-decision latency is 2 cycles.
- Reset values: data_out=0, data_valid=0, busy=0, all error pulses 0, state=IDLE, counters 0, synchronizer=1.
- Reset asserted mid-frame aborts the frame; the partial byte is discarded.
- Tick counter is 16 bits wide. It resets to 0 on every state entry and on every sample point.
- States: IDLE, START, DATA, [PARITY], STOP, BREAK.
- IDLE: when rx_s=0, go to START.
- START: when count==HALF_TICKS-1, sample rx_s. If 0, go to DATA with bit_idx=0. If 1 (glitch), return to IDLE with no error.
- DATA: when count==BAUD_TICKS-1, shift rx_s into shift_reg MSB-ward (LSB first on the line) and increment bit_idx. After the sample with bit_idx==7, go to PARITY if compiled in, else STOP.
- STOP: when count==BAUD_TICKS-1, sample rx_s.
  - If 1 and data_valid=0: data_out<=shift_reg, data_valid<=1, go to IDLE.
  - If 1 and data_valid=1 (not accepted this cycle): pulse overrun_err, drop the new byte, keep the old data_out, go to IDLE.
  - If 0: pulse frame_err, discard the byte, go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents re-triggering on a held-low line.
- Handshake: data_valid clears on the cycle after data_valid & data_ready. Accept and completion in the same cycle count as not overrun: the new byte loads and data_valid stays 1.
- data_valid asserts exactly 1 cycle after the stop-bit sample point.
- Back-to-back frames: a new start edge is accepted on the first IDLE cycle after STOP.
- Only one error pulse is issued per frame. frame_err takes priority over parity_err and overrun_err.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state follows DATA and samples one bit at count==BAUD_TICKS-1. A mismatch against XOR(data)^PARITY_ODD latches a flag. If the stop bit is good, pulse parity_err at the stop sample and discard the byte (data_valid is not set). Frame length is 11 bits.
- Undefined: no PARITY state, 10-bit frame, parity_err tied to 0.

Decomposition:
- Package uart_pkg:
  - state enum uart_rx_state_t (IDLE, START, DATA, PARITY, STOP, BREAK)
  - localparam functions for BAUD_TICKS/HALF_TICKS
  - DATA_BITS=8
  - shared with the transmitter
- One sub-module, uart_sync2: 2-flop synchronizer with reset value 1, reusable for other async inputs.

Test Plan:
- Defaults, send 0xA5 8N1, data_ready=1 -> data_valid one cycle, data_out=0xA5, no errors, busy falls after stop sample.
- Send 0x3C then 0x81 back-to-back with data_ready=0 -> 0x3C held, overrun_err pulse at second stop, data_out stays 0x3C; raise data_ready -> data_valid clears next cycle.
- Send 0x55 with stop bit forced 0, line held low 3 bit times -> frame_err single pulse, no data_valid, busy until line returns high, then next frame 0x12 received correctly.
- 1000-cycle (< HALF_TICKS) low glitch on idle line -> returns to IDLE, no data_valid, no errors.
- rst pulsed during bit 4 of 0xF0 -> all outputs at reset values next cycle; following frame 0x0F received correctly.
- UART_RX_PARITY_EN defined, PARITY_ODD=0: 0x07 with parity 1 -> data_valid, 0x07; same byte with parity 0 -> parity_err pulse, no data_valid.
